// File: rtl/bsg_cache_amo_seq_if.sv
// bsg_cache_amo_seq_if: request, data-array and response bundle of the AMO sequencer
interface bsg_cache_amo_seq_if #(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 64
);
   logic                      v;
   logic                      ready;
   logic [5:0]                opcode;
   logic [addr_width_p-1:0]   addr;
   logic [data_width_p-1:0]   data;
   logic                      mem_v;
   logic                      mem_w;
   logic [addr_width_p-1:0]   mem_addr;
   logic [data_width_p-1:0]   mem_wdata;
   logic [data_width_p/8-1:0] mem_mask;
   logic                      mem_yumi;
   logic [data_width_p-1:0]   mem_rdata;
   logic                      resp_v;
   logic [data_width_p-1:0]   resp_data;
   logic                      resp_yumi;
   modport master (
      output v, opcode, addr, data, mem_yumi, mem_rdata, resp_yumi,
      input  ready, mem_v, mem_w, mem_addr, mem_wdata, mem_mask, resp_v, resp_data
   );
   modport slave (
      input  v, opcode, addr, data, mem_yumi, mem_rdata, resp_yumi,
      output ready, mem_v, mem_w, mem_addr, mem_wdata, mem_mask, resp_v, resp_data
   );
endinterface

// File: rtl/bsg_cache_amo_seq.sv
// bsg_cache_amo_seq: one-at-a-time AMO read-modify-write sequencer over a shared data-array port
package bsg_cache_pkg;
   typedef enum logic [5:0] {
      LB        = 6'b000000, LH        = 6'b000001, LW        = 6'b000010, LD        = 6'b000011,
      SB        = 6'b001000, SH        = 6'b001001, SW        = 6'b001010, SD        = 6'b001011,
      AMOSWAP_W = 6'b100000, AMOADD_W  = 6'b100001, AMOXOR_W  = 6'b100010, AMOAND_W  = 6'b100011,
      AMOOR_W   = 6'b100100, AMOMIN_W  = 6'b100101, AMOMAX_W  = 6'b100110, AMOMINU_W = 6'b100111,
      AMOMAXU_W = 6'b101000,
      AMOSWAP_D = 6'b110000, AMOADD_D  = 6'b110001, AMOXOR_D  = 6'b110010, AMOAND_D  = 6'b110011,
      AMOOR_D   = 6'b110100, AMOMIN_D  = 6'b110101, AMOMAX_D  = 6'b110110, AMOMINU_D = 6'b110111,
      AMOMAXU_D = 6'b111000
   } bsg_cache_opcode_e;
   typedef enum logic [3:0] {
      e_amo_swap, e_amo_add, e_amo_xor, e_amo_and, e_amo_or,
      e_amo_min, e_amo_max, e_amo_minu, e_amo_maxu
   } bsg_cache_amo_subop_e;
   typedef struct packed {
      logic                 atomic_op;
      logic                 double_op;
      bsg_cache_amo_subop_e amo_subop;
   } bsg_cache_decode_s;
endpackage

module bsg_cache_decode
   import bsg_cache_pkg::*;
(
   input  bsg_cache_opcode_e opcode_i,
   output bsg_cache_decode_s decode_o
);
   always_comb begin
      decode_o.atomic_op = opcode_i[5] && (opcode_i[3:0] <= 4'd8);
      decode_o.double_op = opcode_i[4];
      decode_o.amo_subop = bsg_cache_amo_subop_e'(opcode_i[3:0]);
   end
endmodule

module bsg_cache_amo_seq
   import bsg_cache_pkg::*;
#(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 64
) (
   input logic                clk_i,
   input logic                reset_i,
   bsg_cache_amo_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;
   state_e                  state_r, state_n;
   bsg_cache_decode_s       dec_li, dec_r;
   logic [addr_width_p-4:0] addr_r;
   logic                    lane_r;
   logic [31:0]             old_w;
   logic [63:0]             data_r, old_r, a, b, new_val;
   logic                    accept;

   bsg_cache_decode dec (.opcode_i(bsg_cache_opcode_e'(bus.opcode)), .decode_o(dec_li));

   assign accept = bus.v & bus.ready;
   assign old_w  = lane_r ? old_r[63:32] : old_r[31:0];
   // W ops are widened by sign extension so one 64-bit datapath serves both sizes
   assign a      = dec_r.double_op ? old_r : {{32{old_w[31]}}, old_w};
   assign b      = dec_r.double_op ? data_r : {{32{data_r[31]}}, data_r[31:0]};

   always_ff @(posedge clk_i)
      state_r <= reset_i ? IDLE : state_n;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dec_r  <= '0;
         addr_r <= '0;
         lane_r <= 1'b0;
         data_r <= '0;
         old_r  <= '0;
      end else if (accept) begin
         dec_r  <= dec_li;
         addr_r <= bus.addr[addr_width_p-1:3];
         lane_r <= bus.addr[2];
         data_r <= bus.data;
         old_r  <= '0;
      end else if (state_r == RD_WAIT)
         old_r <= bus.mem_rdata;
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    state_n = accept ? (dec_li.atomic_op ? RD_REQ : RESP) : IDLE;
         RD_REQ:  state_n = bus.mem_yumi ? RD_WAIT : RD_REQ;
         RD_WAIT: state_n = WR_REQ;
         WR_REQ:  state_n = bus.mem_yumi ? RESP : WR_REQ;
         RESP:    state_n = bus.resp_yumi ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end

   // sign-extended operands make the unsigned compares order W values correctly too
   always_comb begin
      new_val = a;
      case (dec_r.amo_subop)
         e_amo_swap: new_val = b;
         e_amo_add:  new_val = a + b;
         e_amo_xor:  new_val = a ^ b;
         e_amo_and:  new_val = a & b;
         e_amo_or:   new_val = a | b;
         e_amo_min:  new_val = ($signed(a) < $signed(b)) ? a : b;
         e_amo_max:  new_val = ($signed(a) > $signed(b)) ? a : b;
         e_amo_minu: new_val = (a < b) ? a : b;
         e_amo_maxu: new_val = (a > b) ? a : b;
         default:    new_val = a;
      endcase
   end

   always_comb begin
      bus.ready     = (state_r == IDLE) & ~reset_i;
      bus.mem_v     = ((state_r == RD_REQ) | (state_r == WR_REQ)) & ~reset_i;
      bus.mem_w     = (state_r == WR_REQ) & ~reset_i;
      bus.mem_addr  = {addr_r, 3'b000};
      bus.mem_wdata = dec_r.double_op ? new_val : {2{new_val[31:0]}};
      bus.mem_mask  = (state_r != WR_REQ) ? '0 : dec_r.double_op ? 8'hFF : lane_r ? 8'hF0 : 8'h0F;
      bus.resp_v    = (state_r == RESP) & ~reset_i;
      bus.resp_data = (state_r == RESP) ? a : '0;
   end
endmodule
